// File: rtl/mc_rtype_cpu.sv
// mc_rtype_cpu: multi-cycle MIPS R-type core (IF/WAIT/ID/EX/WB FSM, shared ALU, 32x32 GPR).
// Define MCPU_OVF_TRAP_EN to halt on signed overflow of add/sub instead of wrapping.
module mc_rtype_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int IMEM_AW = 10,
  parameter int IMEM_LAT = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               wb_valid,
  output logic [4:0]         wb_num,
  output logic [31:0]        wb_data,
  output logic [31:0]        pc_o,
  output logic               halted,
  output logic [1:0]         halt_cause
);
  typedef enum logic [2:0] {S_IF, S_WAIT, S_ID, S_EX, S_WB, S_HALT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic [15:0] ir_q, ir_d;
  logic [1:0] cause_q, cause_d, wcnt_q, wcnt_d;
  logic [31:0] gpr_q [32];
  logic [31:0] gpr_d [32];
  logic [31:0] sum, diff, alu_res;
  logic legal_id, ovf;
  assign legal_id = imem_rdata[31:26] == 6'd0 && (imem_rdata[5:0] inside
    {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03});
  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;
`ifdef MCPU_OVF_TRAP_EN
  assign ovf = (ir_q[5:0] == 6'h20 && a_q[31] == b_q[31] && sum[31] != a_q[31]) ||
               (ir_q[5:0] == 6'h22 && a_q[31] != b_q[31] && diff[31] != a_q[31]);
`else
  assign ovf = 1'b0;
`endif
  always_comb begin
    alu_res = '0;
    case (ir_q[5:0])
      6'h20, 6'h21: alu_res = sum;
      6'h22, 6'h23: alu_res = diff;
      6'h24: alu_res = a_q & b_q;
      6'h25: alu_res = a_q | b_q;
      6'h26: alu_res = a_q ^ b_q;
      6'h27: alu_res = ~(a_q | b_q);
      6'h2a: alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
      6'h2b: alu_res = {31'd0, a_q < b_q};
      6'h00: alu_res = b_q << ir_q[10:6];
      6'h02: alu_res = b_q >> ir_q[10:6];
      6'h03: alu_res = $signed(b_q) >>> ir_q[10:6];
      default: alu_res = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    a_d = a_q;
    b_d = b_q;
    alu_d = alu_q;
    cause_d = cause_q;
    wcnt_d = wcnt_q;
    gpr_d = gpr_q;
    case (state_q)
      S_IF: if (run) begin
        state_d = IMEM_LAT > 1 ? S_WAIT : S_ID;
        wcnt_d = 2'(IMEM_LAT - 2);
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 2'd1;
        state_d = wcnt_q == 2'd0 ? S_ID : S_WAIT;
      end
      S_ID: begin
        ir_d = imem_rdata[15:0];
        a_d = imem_rdata[25:21] == 5'd0 ? '0 : gpr_q[imem_rdata[25:21]];
        b_d = imem_rdata[20:16] == 5'd0 ? '0 : gpr_q[imem_rdata[20:16]];
        state_d = legal_id ? S_EX : S_HALT;
        cause_d = legal_id ? cause_q : 2'b01;
      end
      S_EX: begin
        alu_d = alu_res;
        state_d = ovf ? S_HALT : S_WB;
        cause_d = ovf ? 2'b10 : cause_q;
      end
      S_WB: begin
        if (ir_q[15:11] != 5'd0) gpr_d[ir_q[15:11]] = alu_q;
        pc_d = pc_q + 32'd4;
        state_d = S_IF;
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      pc_q <= RESET_PC;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      alu_q <= '0;
      cause_q <= '0;
      wcnt_q <= '0;
      gpr_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q <= a_d;
      b_q <= b_d;
      alu_q <= alu_d;
      cause_q <= cause_d;
      wcnt_q <= wcnt_d;
      gpr_q <= gpr_d;
    end
  end
  // fetch strobe is gated by reset so no fetch escapes while reset is held
  assign imem_en = reset && run && state_q == S_IF;
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign wb_valid = state_q == S_WB;
  assign wb_num = ir_q[15:11];
  assign wb_data = alu_q;
  assign pc_o = pc_q;
  assign halted = state_q == S_HALT;
  assign halt_cause = cause_q;
endmodule

// File: tb/tb_mc_rtype_cpu.sv
// tb_mc_rtype_cpu: randomized self-checking bench for mc_rtype_cpu against an instruction-level model.
module tb_mc_rtype_cpu;
  logic clock = 1'b0, reset = 1'b0, run = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic imem_en, wb_valid, halted;
  logic [9:0] imem_addr;
  logic [4:0] wb_num;
  logic [31:0] wb_data, pc_o;
  logic [1:0] halt_cause;
  int checks = 0, errors = 0, cyc = 0, en_cnt = 0;
  logic [31:0] imem [0:1023];
  logic [31:0] prog[$];
  logic [4:0] q_num[$], e_num[$];
  logic [31:0] q_data[$], e_data[$];
  int q_cyc[$];
  logic [31:0] mg [32];

  mc_rtype_cpu dut (
    .clock(clock), .reset(reset), .run(run), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .wb_valid(wb_valid), .wb_num(wb_num), .wb_data(wb_data),
    .pc_o(pc_o), .halted(halted), .halt_cause(halt_cause)
  );

  always #5 clock = ~clock;
  always @(posedge clock) begin
    cyc++;
    if (imem_en) imem_rdata <= imem[imem_addr];
  end
  always @(negedge clock) begin
    if (imem_en) en_cnt++;
    if (wb_valid) begin
      q_num.push_back(wb_num);
      q_data.push_back(wb_data);
      q_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] r(input logic [5:0] fn, input logic [4:0] rd, rs, rt, sh);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [5:0] fn, input logic [31:0] a, b, input logic [4:0] sh);
    case (fn)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2a: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2b: return (a < b) ? 32'd1 : 32'd0;
      6'h00: return b << sh;
      6'h02: return b >> sh;
      6'h03: return 32'($signed(b) >>> sh);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic model_prog(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] ins, res;
      ins = prog[i];
      res = ref_alu(ins[5:0], mg[ins[25:21]], mg[ins[20:16]], ins[10:6]);
      e_num.push_back(ins[15:11]);
      e_data.push_back(res);
      if (ins[15:11] != 5'd0) mg[ins[15:11]] = res;
    end
  endtask

  task automatic start();
    for (int i = 0; i < 1024; i++) imem[i] = i < prog.size() ? prog[i] : 32'd0;
    reset = 1'b0;
    run = 1'b0;
    repeat (3) @(negedge clock);
    q_num.delete(); q_data.delete(); q_cyc.delete(); e_num.delete(); e_data.delete();
    for (int i = 0; i < 32; i++) mg[i] = '0;
    reset = 1'b1;
    run = 1'b1;
  endtask

  task automatic wait_n(input int n, output bit to);
    for (int i = 0; i < 2000 && q_num.size() < n; i++) begin
      @(negedge clock);
      #1;
    end
    to = q_num.size() < n;
  endtask

  task automatic seed();
    prog = {r(6'h27, 31, 0, 0, 0), r(6'h22, 30, 0, 31, 0), r(6'h00, 1, 0, 30, 2),
            r(6'h21, 1, 1, 30, 0), r(6'h00, 2, 0, 30, 3), r(6'h23, 2, 2, 30, 0)};
  endtask

  task automatic test_reset();
    prog.delete();
    for (int i = 0; i < 1024; i++) imem[i] = '0;
    reset = 1'b0;
    run = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (pc_o !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h want 00003000", pc_o); end
    checks++; if ({halted, wb_valid, imem_en, halt_cause} !== 5'b0) begin errors++; $display("FAIL reset_outs got %b want 00000", {halted, wb_valid, imem_en, halt_cause}); end
    checks++; if (wb_data !== 32'd0 || wb_num !== 5'd0) begin errors++; $display("FAIL reset_wb got %0d/%h want 0/0", wb_num, wb_data); end
    reset = 1'b1;
    #1;
    checks++; if (imem_en !== 1'b1 || imem_addr !== 10'h000) begin errors++; $display("FAIL first_fetch got en=%b addr=%h want 1/000", imem_en, imem_addr); end
  endtask

  task automatic test_arith();
    bit to;
    seed();
    prog.push_back(r(6'h20, 3, 1, 2, 0));
    prog.push_back(r(6'h22, 4, 1, 2, 0));
    start();
    model_prog(8);
    wait_n(8, to);
    checks++; if (to) begin errors++; $display("FAIL arith_timeout got %0d retires want 8", q_num.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q_num[i] !== e_num[i] || q_data[i] !== e_data[i]) begin errors++; $display("FAIL arith[%0d] got rd=%0d data=%h want rd=%0d data=%h", i, q_num[i], q_data[i], e_num[i], e_data[i]); end
    end
    checks++; if (q_data[6] !== 32'd12 || q_data[7] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL arith_const got %h %h want 0000000c fffffffe", q_data[6], q_data[7]); end
    checks++; if (q_cyc[7] - q_cyc[6] !== 4) begin errors++; $display("FAIL arith_spacing got %0d want 4", q_cyc[7] - q_cyc[6]); end
  endtask

  task automatic test_shift();
    bit to;
    prog = {r(6'h27, 31, 0, 0, 0), r(6'h22, 30, 0, 31, 0), r(6'h00, 1, 0, 30, 31),
            r(6'h03, 5, 0, 1, 4), r(6'h02, 6, 0, 1, 4), r(6'h2a, 7, 1, 0, 0), r(6'h2b, 8, 1, 0, 0)};
    start();
    model_prog(7);
    wait_n(7, to);
    checks++; if (to) begin errors++; $display("FAIL shift_timeout got %0d retires want 7", q_num.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (q_num[i] !== e_num[i] || q_data[i] !== e_data[i]) begin errors++; $display("FAIL shift[%0d] got rd=%0d data=%h want rd=%0d data=%h", i, q_num[i], q_data[i], e_num[i], e_data[i]); end
    end
    checks++;
    if ({q_data[3], q_data[4], q_data[5], q_data[6]} !== {32'hF800_0000, 32'h0800_0000, 32'd1, 32'd0}) begin
      errors++; $display("FAIL shift_const got %h %h %h %h want f8000000 08000000 1 0", q_data[3], q_data[4], q_data[5], q_data[6]);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    seed();
    prog.push_back(r(6'h25, 9, 0, 2, 0));
    prog.push_back(r(6'h20, 10, 9, 9, 0));
    prog.push_back(r(6'h20, 0, 1, 2, 0));
    prog.push_back(r(6'h25, 11, 0, 30, 0));
    start();
    model_prog(10);
    wait_n(10, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout got %0d retires want 10", q_num.size()); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (q_num[i] !== e_num[i] || q_data[i] !== e_data[i]) begin errors++; $display("FAIL b2b[%0d] got rd=%0d data=%h want rd=%0d data=%h", i, q_num[i], q_data[i], e_num[i], e_data[i]); end
    end
    checks++; if (q_data[7] !== 32'd14 || q_num[8] !== 5'd0 || q_data[9] !== 32'd1) begin errors++; $display("FAIL b2b_const got %h %0d %h want 0000000e 0 00000001", q_data[7], q_num[8], q_data[9]); end
  endtask

  task automatic test_illegal();
    int en0;
    prog = {r(6'h27, 31, 0, 0, 0), 32'h8C00_0000, r(6'h27, 1, 0, 0, 0)};
    start();
    for (int i = 0; i < 200 && !halted; i++) @(negedge clock);
    checks++; if (halted !== 1'b1 || halt_cause !== 2'b01) begin errors++; $display("FAIL illegal_halt got halted=%b cause=%b want 1/01", halted, halt_cause); end
    checks++; if (pc_o !== 32'h3004) begin errors++; $display("FAIL illegal_pc got %h want 00003004", pc_o); end
    en0 = en_cnt;
    repeat (20) @(negedge clock);
    #1;
    checks++; if (en_cnt - en0 !== 0 || q_num.size() !== 1) begin errors++; $display("FAIL illegal_frozen got fetches=%0d retires=%0d want 0/1", en_cnt - en0, q_num.size()); end
  endtask

  task automatic test_run_stall();
    bit to;
    int en0;
    seed();
    start();
    model_prog(6);
    wait_n(2, to);
    run = 1'b0;
    en0 = en_cnt;
    repeat (20) @(negedge clock);
    #1;
    checks++; if (en_cnt - en0 !== 0 || q_num.size() !== 2 || pc_o !== 32'h3008) begin errors++; $display("FAIL stall got fetches=%0d retires=%0d pc=%h want 0/2/00003008", en_cnt - en0, q_num.size(), pc_o); end
    run = 1'b1;
    wait_n(6, to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout got %0d retires want 6", q_num.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (q_num[i] !== e_num[i] || q_data[i] !== e_data[i]) begin errors++; $display("FAIL stall[%0d] got rd=%0d data=%h want rd=%0d data=%h", i, q_num[i], q_data[i], e_num[i], e_data[i]); end
    end
  endtask

  task automatic test_random();
    bit to;
    logic [5:0] fl [11] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03};
    prog = {r(6'h27, 31, 0, 0, 0), r(6'h22, 30, 0, 31, 0)};
    for (int i = 0; i < 40; i++)
      prog.push_back(r(fl[$urandom_range(0, 10)], 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))));
    start();
    model_prog(42);
    wait_n(42, to);
    checks++; if (to) begin errors++; $display("FAIL random_timeout got %0d retires want 42", q_num.size()); end
    for (int i = 0; i < 42; i++) begin
      checks++;
      if (q_num[i] !== e_num[i] || q_data[i] !== e_data[i]) begin errors++; $display("FAIL random[%0d] ins=%h got rd=%0d data=%h want rd=%0d data=%h", i, prog[i], q_num[i], q_data[i], e_num[i], e_data[i]); end
    end
  endtask

  task automatic test_ovf();
    bit to;
    prog = {r(6'h27, 31, 0, 0, 0), r(6'h22, 30, 0, 31, 0), r(6'h00, 1, 0, 30, 31),
            r(6'h27, 1, 1, 0, 0), r(6'h20, 2, 1, 1, 0), r(6'h25, 3, 0, 2, 0)};
    start();
`ifdef MCPU_OVF_TRAP_EN
    model_prog(4);
    for (int i = 0; i < 200 && !halted; i++) @(negedge clock);
    repeat (5) @(negedge clock);
    #1;
    checks++; if (halted !== 1'b1 || halt_cause !== 2'b10 || pc_o !== 32'h3010) begin errors++; $display("FAIL ovf_trap got halted=%b cause=%b pc=%h want 1/10/00003010", halted, halt_cause, pc_o); end
    checks++; if (q_num.size() !== 4) begin errors++; $display("FAIL ovf_retires got %0d want 4", q_num.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_num[i] !== e_num[i] || q_data[i] !== e_data[i]) begin errors++; $display("FAIL ovf[%0d] got rd=%0d data=%h want rd=%0d data=%h", i, q_num[i], q_data[i], e_num[i], e_data[i]); end
    end
`else
    model_prog(6);
    wait_n(6, to);
    checks++; if (to) begin errors++; $display("FAIL ovf_timeout got %0d retires want 6", q_num.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (q_num[i] !== e_num[i] || q_data[i] !== e_data[i]) begin errors++; $display("FAIL ovf[%0d] got rd=%0d data=%h want rd=%0d data=%h", i, q_num[i], q_data[i], e_num[i], e_data[i]); end
    end
    checks++; if (q_num[4] !== 5'd2 || q_data[4] !== 32'hFFFF_FFFE || halt_cause !== 2'b00) begin errors++; $display("FAIL ovf_wrap got rd=%0d data=%h cause=%b want 2/fffffffe/00", q_num[4], q_data[4], halt_cause); end
`endif
  endtask

  task automatic test_reset_in_ex();
    bit to;
    prog = {r(6'h27, 31, 0, 0, 0), r(6'h25, 5, 0, 31, 0)};
    start();
    wait_n(1, to);
    repeat (3) @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    checks++; if (pc_o !== 32'h3000 || wb_valid !== 1'b0 || imem_en !== 1'b0) begin errors++; $display("FAIL rst_ex got pc=%h wbv=%b en=%b want 00003000/0/0", pc_o, wb_valid, imem_en); end
    repeat (3) @(negedge clock);
    #1;
    checks++; if (q_num.size() !== 1) begin errors++; $display("FAIL rst_ex_nowb got %0d retires want 1", q_num.size()); end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_back_to_back();
    test_illegal();
    test_run_stall();
    test_random();
    test_ovf();
    test_reset_in_ex();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
